// File: rtl/proc_wait_timer_if.sv
// -----------------------------------------------------------------------------
// proc_wait_timer_if
//
// Bundles the command handshake, the per-channel time buses, the clock-gate
// controls and the status outputs of proc_wait_timer.
//
// Parameters
//   CH : number of channels (>= 2)
//   W  : time / counter width in bits
//
// Signals (direction seen from the timer, i.e. the slave modport)
//   cmd_valid  in   command request
//   cmd_ready  out  command accept; transfer on cmd_valid && cmd_ready
//   cmd_type   in   1=load rel, 2=load ext, 3=load reftime, 4=abort,
//                   5=periodic load (reload build only), others=no-op
//   cmd_ch     in   target channel; values >= CH are an accepted no-op
//   rel_time   in   per-channel relative time, channel i at [i*W +: W]
//   ext_time   in   per-channel external time, same packing
//   event_ref  in   per-channel event reference, sampled every cycle
//   ckg_force  in   forces the clock-gate enable high
//   ckg_ind    in   indication captured under the gate enable
//   busy       out  per-channel counting flag
//   expire     out  per-channel one-cycle expiry pulse
//   ckg_en     out  registered clock-gate enable
//   ckg_ind_1d out  gated capture of ckg_ind
// -----------------------------------------------------------------------------
interface proc_wait_timer_if #(
  parameter int CH = 2,
  parameter int W  = 8
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [4:0]      cmd_type;
  logic [CHW-1:0]  cmd_ch;
  logic [CH*W-1:0] rel_time;
  logic [CH*W-1:0] ext_time;
  logic [CH*W-1:0] event_ref;
  logic            ckg_force;
  logic            ckg_ind;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   expire;
  logic            ckg_en;
  logic            ckg_ind_1d;

  // Command / time source side.
  modport master (
    output cmd_valid, cmd_type, cmd_ch, rel_time, ext_time, event_ref,
           ckg_force, ckg_ind,
    input  cmd_ready, busy, expire, ckg_en, ckg_ind_1d
  );

  // Timer side.
  modport slave (
    input  cmd_valid, cmd_type, cmd_ch, rel_time, ext_time, event_ref,
           ckg_force, ckg_ind,
    output cmd_ready, busy, expire, ckg_en, ckg_ind_1d
  );
endinterface

// File: rtl/proc_wait_timer.sv
// -----------------------------------------------------------------------------
// proc_wait_timer
//
// Multi-channel wait-time engine. Each channel owns a W-bit down-counter that
// is loaded on command from a relative time, an external time, or a one-cycle
// old copy of the event reference. When a counter runs out the channel pulses
// its expire flag for one cycle. A registered clock-gate enable (any channel
// busy next cycle, or forced) qualifies a downstream indication flop; no
// derived clock is produced.
//
// Build option
//   PROC_WAIT_RELOAD_EN : when defined, cmd_type 5 performs a periodic load.
//                         The channel reloads its counter on every expiry and
//                         keeps counting until aborted. When undefined,
//                         cmd_type 5 is a no-op and the reload/periodic
//                         registers are not built.
//
// Ports
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : proc_wait_timer_if.slave (command handshake, time buses,
//         clock-gate controls, busy/expire/ckg status)
// -----------------------------------------------------------------------------
module proc_wait_timer #(
  parameter int CH = 2,
  parameter int W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  proc_wait_timer_if.slave bus
);

  typedef enum logic [4:0] {
    CMD_LOAD_REL = 5'd1,
    CMD_LOAD_EXT = 5'd2,
    CMD_LOAD_REF = 5'd3,
    CMD_ABORT    = 5'd4,
    CMD_LOAD_PER = 5'd5
  } cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q   [CH];
  state_e        state_d   [CH];
  logic [W-1:0]  cnt_q     [CH];
  logic [W-1:0]  cnt_d     [CH];
  logic [W-1:0]  reftime_q [CH];
  logic [CH-1:0] expire_q;
  logic [CH-1:0] expire_d;
  logic          ckg_en_q;
  logic          ckg_en_d;
  logic          ckg_ind_1d_q;

`ifdef PROC_WAIT_RELOAD_EN
  logic [W-1:0]  reload_q  [CH];
  logic [W-1:0]  reload_d  [CH];
  logic [CH-1:0] periodic_q;
  logic [CH-1:0] periodic_d;
`endif

  logic [CH-1:0] busy_q;
  logic [CH-1:0] busy_d;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic          ch_valid;   // cmd_ch names an existing channel
  logic          sel_busy;   // the addressed channel is counting
  logic          is_abort;
  logic          is_load;
  logic          cmd_ready;
  logic          cmd_fire;
  logic [CH-1:0] hit;        // accepted command addresses channel i
  logic [W-1:0]  load_val [CH];

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    ch_valid = 1'b0;
    sel_busy = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (int'(bus.cmd_ch) == i) begin
        ch_valid = 1'b1;
        sel_busy = (state_q[i] == ST_COUNT);
      end
    end
  end

  assign is_abort = (bus.cmd_type == CMD_ABORT);

`ifdef PROC_WAIT_RELOAD_EN
  assign is_load = (bus.cmd_type == CMD_LOAD_REL) ||
                   (bus.cmd_type == CMD_LOAD_EXT) ||
                   (bus.cmd_type == CMD_LOAD_REF) ||
                   (bus.cmd_type == CMD_LOAD_PER);
`else
  assign is_load = (bus.cmd_type == CMD_LOAD_REL) ||
                   (bus.cmd_type == CMD_LOAD_EXT) ||
                   (bus.cmd_type == CMD_LOAD_REF);
`endif

  // Loads stall on a counting channel; aborts and out-of-range channels never
  // stall. A periodic channel stays counting, so it also refuses loads.
  assign cmd_ready = !sel_busy || is_abort || !ch_valid;
  assign cmd_fire  = bus.cmd_valid && cmd_ready;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      hit[i] = cmd_fire && (int'(bus.cmd_ch) == i);
    end
  end

  // Load value per channel. Reftime is the registered event reference, so a
  // reftime load sees the value event_ref had one cycle earlier. Type 5 uses
  // the relative time like type 1.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      case (bus.cmd_type)
        CMD_LOAD_EXT: load_val[i] = bus.ext_time[i*W +: W];
        CMD_LOAD_REF: load_val[i] = reftime_q[i];
        default:      load_val[i] = bus.rel_time[i*W +: W];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      expire_d[i] = 1'b0;
`ifdef PROC_WAIT_RELOAD_EN
      reload_d[i]   = reload_q[i];
      periodic_d[i] = periodic_q[i];
`endif

      if (hit[i] && is_abort) begin
        // Abort takes priority over a final count landing on the same edge,
        // so the expire pulse is suppressed.
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
`ifdef PROC_WAIT_RELOAD_EN
        periodic_d[i] = 1'b0;
`endif
      end else if (hit[i] && is_load) begin
        // Only reachable from IDLE: cmd_ready holds loads off a busy channel.
        if (load_val[i] == '0) begin
          // Zero wait: stay idle and report expiry straight away.
          state_d[i]  = ST_IDLE;
          cnt_d[i]    = '0;
          expire_d[i] = 1'b1;
        end else begin
          state_d[i] = ST_COUNT;
          cnt_d[i]   = load_val[i];
        end
`ifdef PROC_WAIT_RELOAD_EN
        // A periodic load of 0 degenerates to a one-shot, so no flag.
        reload_d[i]   = load_val[i];
        periodic_d[i] = (bus.cmd_type == CMD_LOAD_PER) && (load_val[i] != '0);
`endif
      end else if (state_q[i] == ST_COUNT) begin
        // The <= guard keeps the counter from ever wrapping below zero.
        if (cnt_q[i] <= W'(1)) begin
          expire_d[i] = 1'b1;
`ifdef PROC_WAIT_RELOAD_EN
          if (periodic_q[i]) begin
            cnt_d[i] = reload_q[i];
          end else begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
`else
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] - W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      busy_q[i] = (state_q[i] == ST_COUNT);
      busy_d[i] = (state_d[i] == ST_COUNT);
    end
  end

  // Gate enable looks one cycle ahead so it is already high in the first
  // busy cycle.
  assign ckg_en_d = (|busy_d) || bus.ckg_force;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these per-channel arrays are a few flops each, not RAM, so they
      // are reset like any other register; a reset mid-count must leave every
      // counter and reference at zero.
      for (int i = 0; i < CH; i++) begin
        state_q[i]   <= ST_IDLE;
        cnt_q[i]     <= '0;
        reftime_q[i] <= '0;
`ifdef PROC_WAIT_RELOAD_EN
        reload_q[i]  <= '0;
`endif
      end
`ifdef PROC_WAIT_RELOAD_EN
      periodic_q   <= '0;
`endif
      expire_q     <= '0;
      ckg_en_q     <= 1'b0;
      ckg_ind_1d_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      for (int i = 0; i < CH; i++) begin
        state_q[i]   <= state_d[i];
        cnt_q[i]     <= cnt_d[i];
        reftime_q[i] <= bus.event_ref[i*W +: W];
`ifdef PROC_WAIT_RELOAD_EN
        reload_q[i]  <= reload_d[i];
`endif
      end
`ifdef PROC_WAIT_RELOAD_EN
      periodic_q <= periodic_d;
`endif
      expire_q <= expire_d;
      ckg_en_q <= ckg_en_d;
      // Enable-qualified capture: the indication flop only updates while
      // the current gate enable is high.
      if (ckg_en_q) begin
        ckg_ind_1d_q <= bus.ckg_ind;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready  = cmd_ready;
  assign bus.busy       = busy_q;
  assign bus.expire     = expire_q;
  assign bus.ckg_en     = ckg_en_q;
  assign bus.ckg_ind_1d = ckg_ind_1d_q;

endmodule

// File: tb/tb_proc_wait_timer.sv
// -----------------------------------------------------------------------------
// tb_proc_wait_timer
//
// Self-checking bench for proc_wait_timer (CH=2, W=8). A timestamp-based model
// tracks, per channel, whether it is counting, the edge on which it is due,
// its period (periodic loads) and the edge of its last expiry. A compare
// process checks every DUT output against the model on each falling edge.
// Directed sequences pin the model with literal expectations, followed by a
// randomized phase with occasional mid-run resets.
// -----------------------------------------------------------------------------
module tb_proc_wait_timer;
  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  proc_wait_timer_if #(.CH(CH), .W(W)) bus ();
  proc_wait_timer #(.CH(CH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: timestamps in edges since reset
  // ---------------------------------------------------------------------------
  int           m_cyc;
  bit           m_act      [CH];
  int           m_due      [CH];
  int           m_per      [CH];
  int           m_exp_edge [CH];
  logic [W-1:0] m_ref      [CH];
  bit           m_ckg;
  bit           m_ind;

  function automatic void model_reset();
    m_cyc = 0;
    for (int i = 0; i < CH; i++) begin
      m_act[i] = 0; m_due[i] = 0; m_per[i] = 0; m_exp_edge[i] = -1; m_ref[i] = '0;
    end
    m_ckg = 0;
    m_ind = 0;
  endfunction

  function automatic bit m_is_load(input logic [4:0] t);
`ifdef PROC_WAIT_RELOAD_EN
    return (t == 5'd1) || (t == 5'd2) || (t == 5'd3) || (t == 5'd5);
`else
    return (t == 5'd1) || (t == 5'd2) || (t == 5'd3);
`endif
  endfunction

  function automatic bit m_ready();
    int c;
    c = int'(bus.cmd_ch);
    if (c >= CH) return 1'b1;
    return !m_act[c] || (bus.cmd_type == 5'd4);
  endfunction

  task automatic model_step();
    int e, c, n;
    bit acc, hit, ab, en_next;
    e   = m_cyc + 1;
    acc = bus.cmd_valid && m_ready();
    c   = int'(bus.cmd_ch);
    for (int i = 0; i < CH; i++) begin
      hit = acc && (c == i);
      ab  = hit && (bus.cmd_type == 5'd4);
      if (m_act[i] && (m_due[i] == e) && !ab) begin
        m_exp_edge[i] = e;
        if (m_per[i] > 0) m_due[i] = e + m_per[i];
        else m_act[i] = 0;
      end
      if (ab) begin
        m_act[i] = 0;
        m_per[i] = 0;
      end
      if (hit && m_is_load(bus.cmd_type)) begin
        case (bus.cmd_type)
          5'd2:    n = int'(bus.ext_time[i*W +: W]);
          5'd3:    n = int'(m_ref[i]);
          default: n = int'(bus.rel_time[i*W +: W]);
        endcase
        if (n == 0) begin
          m_exp_edge[i] = e;
        end else begin
          m_act[i] = 1;
          m_due[i] = e + n;
          m_per[i] = (bus.cmd_type == 5'd5) ? n : 0;
        end
      end
    end
    en_next = bus.ckg_force;
    for (int i = 0; i < CH; i++) if (m_act[i]) en_next = 1;
    if (m_ckg) m_ind = bus.ckg_ind;
    m_ckg = en_next;
    for (int i = 0; i < CH; i++) m_ref[i] = bus.event_ref[i*W +: W];
    m_cyc = e;
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) model_step();
  end

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  initial forever begin
    logic [CH-1:0] eb, ee;
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      eb[i] = m_act[i];
      ee[i] = (m_exp_edge[i] == m_cyc);
    end
    check("cmp_ready",  bus.cmd_ready,  m_ready());
    check("cmp_busy",   bus.busy,       eb);
    check("cmp_expire", bus.expire,     ee);
    check("cmp_ckg_en", bus.ckg_en,     m_ckg);
    check("cmp_ind_1d", bus.ckg_ind_1d, m_ind);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+2)
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    bus.cmd_valid = 0; bus.cmd_type = '0; bus.cmd_ch = '0;
    bus.rel_time = '0; bus.ext_time = '0; bus.event_ref = '0;
    bus.ckg_force = 0; bus.ckg_ind = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rel(input int ch, input int v);
    bus.rel_time[ch*W +: W] = W'(v);
  endtask

  task automatic issue(input logic [4:0] t, input int ch);
    bus.cmd_valid = 1; bus.cmd_type = t; bus.cmd_ch = CHW'(ch);
    tick();
    bus.cmd_valid = 0; bus.cmd_type = '0;
  endtask

  // Watches one channel for len samples after an accepted load.
  task automatic observe(input int ch, input int len, output int bc, output int ec, output int ei);
    bc = 0; ec = 0; ei = -1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (bus.busy[ch]) bc++;
      if (bus.expire[ch]) begin ec++; ei = i; end
      tick();
    end
  endtask

  task automatic randomize_inputs();
    bus.cmd_valid = ($urandom_range(0, 9) < 7);
    bus.cmd_type  = 5'($urandom_range(0, 6));
    bus.cmd_ch    = CHW'($urandom_range(0, (1 << CHW) - 1));
    for (int i = 0; i < CH; i++) begin
      bus.rel_time[i*W +: W]  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 10));
      bus.ext_time[i*W +: W]  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 10));
      bus.event_ref[i*W +: W] = W'($urandom_range(0, 10));
    end
    bus.ckg_force = ($urandom_range(0, 15) == 0);
    bus.ckg_ind   = 1'($urandom_range(0, 1));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int bc, ec, ei, cm, stall, holds, follows, pre, post, busy_cnt;
    logic exp_at_rise, b3, b4, b13, v_prev, v;
    bit got;

    model_reset();
    idle_inputs();

    // Reset held with random inputs: all outputs stay 0.
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      @(negedge clk);
      check("rst_busy",   bus.busy,       '0);
      check("rst_expire", bus.expire,     '0);
      check("rst_ckg_en", bus.ckg_en,     '0);
      check("rst_ind_1d", bus.ckg_ind_1d, '0);
    end
    @(posedge clk); #2;
    idle_inputs();
    bus.cmd_type = 5'd1;
    bus.cmd_ch   = CHW'($urandom_range(0, (1 << CHW) - 1));
    rst = 1;
    @(negedge clk);
    check("rel_ready", bus.cmd_ready, 1'b1);
    tick();
    idle_inputs();

    // Load rel=5 on ch0.
    set_rel(0, 5);
    issue(5'd1, 0);
    cm = 0;
    bc = 0; ec = 0; ei = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy[0]) bc++;
      if (bus.expire[0]) begin ec++; ei = i; end
      if (bus.ckg_en == bus.busy[0]) cm++;
      tick();
    end
    check("ld5_busy_cycles", bc, 5);
    check("ld5_exp_count",   ec, 1);
    check("ld5_exp_index",   ei, 5);
    check("ld5_ckg_track",   cm, 10);

    // Load-3 on ch1: registered reference 3 is used, not the new 7.
    bus.event_ref[W +: W] = 8'd3;
    tick();
    bus.event_ref[W +: W] = 8'd7;
    issue(5'd3, 1);
    observe(1, 8, bc, ec, ei);
    check("ref_busy_cycles", bc, 3);
    check("ref_exp_count",   ec, 1);
    check("ref_exp_index",   ei, 3);

    // Abort ch0 on the edge where cnt==1.
    set_rel(0, 4);
    issue(5'd1, 0);
    ec = 0; b3 = 0; b4 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.expire[0]) ec++;
      if (i == 3) b3 = bus.busy[0];
      if (i == 4) b4 = bus.busy[0];
      tick();
      if (i == 2) begin bus.cmd_valid = 1; bus.cmd_type = 5'd4; bus.cmd_ch = '0; end
      if (i == 3) begin bus.cmd_valid = 0; bus.cmd_type = '0; end
    end
    check("abort_exp_count", ec, 0);
    check("abort_busy_pre",  b3, 1'b1);
    check("abort_busy_post", b4, 1'b0);

    // Second load on busy ch1 stalls until ch1 expires.
    set_rel(1, 6);
    issue(5'd1, 1);
    set_rel(1, 2);
    bus.cmd_valid = 1; bus.cmd_type = 5'd1; bus.cmd_ch = CHW'(1);
    stall = 0; got = 0; exp_at_rise = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        got = 1;
        exp_at_rise = bus.expire[1];
      end else begin
        stall++;
        tick();
      end
    end
    check("stall_cycles",  stall, 6);
    check("stall_exp_set", exp_at_rise, 1'b1);
    tick();
    bus.cmd_valid = 0; bus.cmd_type = '0;
    repeat (4) tick();

    // Gate: capture 1 under force, then hold while nothing is busy.
    bus.ckg_force = 1; bus.ckg_ind = 1;
    tick(); tick();
    bus.ckg_force = 0;
    tick(); tick();
    holds = 0;
    for (int i = 0; i < 6; i++) begin
      bus.ckg_ind = ~bus.ckg_ind;
      @(negedge clk);
      if (bus.ckg_ind_1d === 1'b1) holds++;
      tick();
    end
    check("gate_hold", holds, 6);

    // Gate: follow ckg_ind with one cycle delay while busy.
    set_rel(0, 10);
    issue(5'd1, 0);
    follows = 0; v_prev = 0;
    for (int i = 0; i < 8; i++) begin
      v = 1'($urandom_range(0, 1));
      bus.ckg_ind = v;
      @(negedge clk);
      if (i > 0 && bus.ckg_ind_1d === v_prev) follows++;
      v_prev = v;
      tick();
    end
    check("gate_follow", follows, 7);
    issue(5'd4, 0);
    tick();

    // Periodic load of 4 on ch0, aborted after three periods.
    set_rel(0, 4);
    issue(5'd5, 0);
    pre = 0; post = 0; busy_cnt = 0; b13 = 1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (bus.expire[0]) begin
        if (i <= 12) pre++; else post++;
      end
      if (i <= 12 && bus.busy[0]) busy_cnt++;
      if (i == 13) b13 = bus.busy[0];
      tick();
      if (i == 11) begin bus.cmd_valid = 1; bus.cmd_type = 5'd4; bus.cmd_ch = '0; end
      if (i == 12) begin bus.cmd_valid = 0; bus.cmd_type = '0; end
    end
`ifdef PROC_WAIT_RELOAD_EN
    check("per_pulses",     pre, 3);
    check("per_busy",       busy_cnt, 13);
`else
    check("per_pulses",     pre, 0);
    check("per_busy",       busy_cnt, 0);
`endif
    check("per_after_abort", post, 0);
    check("per_busy_after",  b13, 1'b0);

    // Randomized phase with occasional mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      if ($urandom_range(0, 399) == 0) begin
        rst = 0;
        model_reset();
        tick(); tick();
        rst = 1;
      end
      tick();
    end

    idle_inputs();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
